hash_host_drv: RTL

Host-side driver for the BLAKE2 byte-stream hasher. It takes a message from a host byte stream and issues the hasher's start, data and finish sequence. It then deserializes the W-byte digest that the hasher returns LSB-first into a parallel register. It sits between the host/test harness and the hasher's data manager, acting as the transmitter for its message input and the receiver for its digest output.

---
 rtl/hash_host_drv_if.sv | 28 ++
 rtl/hash_host_drv.sv | 94 +++++++++
 2 files changed

// File: rtl/hash_host_drv_if.sv
// hash_host_drv_if: host byte stream, hasher byte/digest links and status for hash_host_drv
interface hash_host_drv_if #(parameter int W = 32);
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_ready;
  logic           empty_req;
  logic [7:0]     h_data;
  logic           h_dv;
  logic           h_drdy;
  logic           h_start;
  logic           h_finish;
  logic [7:0]     d_data;
  logic           d_dv;
  logic           d_end;
  logic [W*8-1:0] digest;
  logic           digest_valid;
  logic           busy;
  logic           err;
  modport slave (
    input  s_data, s_valid, s_last, empty_req, h_drdy, d_data, d_dv, d_end,
    output s_ready, h_data, h_dv, h_start, h_finish, digest, digest_valid, busy, err
  );
  modport master (
    output s_data, s_valid, s_last, empty_req, h_drdy, d_data, d_dv, d_end,
    input  s_ready, h_data, h_dv, h_start, h_finish, digest, digest_valid, busy, err
  );
endinterface

// File: rtl/hash_host_drv.sv
// hash_host_drv: drives the hasher start/data/finish sequence and collects the LSB-first digest
module hash_host_drv #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hash_host_drv_if.slave bus
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] FIN    = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  logic [2:0]     state_q, state_d;
  logic           empty_q, empty_d;
  logic           dvalid_q, dvalid_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W*8-1:0] dig_q, dig_d;
  logic           in_stream, hs, wth;
  always_comb begin
    in_stream = state_q == STREAM;
    hs        = in_stream & bus.s_valid & bus.h_drdy;
    wth       = cnt_q == CW'(W - 1);
    state_d   = state_q;
    empty_d   = empty_q;
    dvalid_d  = dvalid_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    case (state_q)
      IDLE: begin
        state_d = (bus.s_valid | bus.empty_req) ? START : IDLE;
        empty_d = bus.empty_req & ~bus.s_valid;
      end
      START: begin
        state_d  = empty_q ? FIN : STREAM;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = '0;
      end
      STREAM: state_d = (hs & bus.s_last) ? WAIT : STREAM;
      FIN: begin
        state_d = WAIT;
        empty_d = 1'b0;
      end
      WAIT: if (bus.d_dv) begin
        dig_d = {bus.d_data, dig_q[W*8-1:8]};
        cnt_d = (cnt_q == CW'(W)) ? cnt_q : cnt_q + 1'b1;
        // a W-th byte without d_end is a framing error, but we still wait for d_end
        if (bus.d_end) begin
          state_d  = IDLE;
          dvalid_d = wth;
          err_d    = err_q | ~wth;
        end else if (wth) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.d_dv && state_q != WAIT) err_d = 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      empty_q  <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      dig_q    <= '0;
    end else begin
      state_q  <= state_d;
      empty_q  <= empty_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
    end
  end
  assign bus.s_ready      = in_stream & bus.h_drdy;
  assign bus.h_dv         = hs;
  assign bus.h_data       = in_stream ? bus.s_data : 8'h00;
  assign bus.h_start      = state_q == START;
  assign bus.h_finish     = (hs & bus.s_last) | (state_q == FIN);
  assign bus.digest       = dig_q;
  assign bus.digest_valid = dvalid_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
endmodule
